// File: rtl/coin_pkg.sv
// coin_pkg: shared constants for the coin-sensor conditioning stage.
//   - bit positions of each coin within the raw button vector
//   - coin values and the width of the reported coin value
//   - packed payload of the registered coin-stage outputs
package coin_pkg;

    localparam int unsigned COIN5_BIT   = 4;
    localparam int unsigned SPARE_BIT   = 3;
    localparam int unsigned COIN25_BIT  = 2;
    localparam int unsigned COIN100_BIT = 1;
    localparam int unsigned COIN10_BIT  = 0;

    localparam int unsigned COIN_VAL_W = 7;

    localparam logic [COIN_VAL_W-1:0] COIN5_VAL   = 7'd5;
    localparam logic [COIN_VAL_W-1:0] COIN10_VAL  = 7'd10;
    localparam logic [COIN_VAL_W-1:0] COIN25_VAL  = 7'd25;
    localparam logic [COIN_VAL_W-1:0] COIN100_VAL = 7'd100;

    // Registered result of the coin mapping / collision stage.
    typedef struct packed {
        logic                  s5;
        logic                  s10;
        logic                  s25;
        logic                  s100;
        logic [COIN_VAL_W-1:0] value;
        logic                  err;
    } coin_out_t;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: conditions one raw asynchronous input.
//   2-flop synchroniser, consecutive-edge debounce counter, stable level,
//   and a one-cycle pulse when the stable level rises.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   i_raw    raw input, asynchronous to clk
//   o_level  debounced stable level (registered)
//   o_pulse  one-cycle pulse on a 0->1 change of o_level (registered)
module debounce_bit #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    // Count value at which the next differing edge commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_q1;
    logic             r_q2;
    logic             r_stable;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= i_raw;
            r_q2 <= r_q1;
        end
    end

    // Debounce: any agreement with the stable level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (r_q2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_q2;
                r_cnt    <= '0;
                r_pulse  <= r_q2;    // only a rise produces a pulse
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/coin_sensor_cond.sv
// coin_sensor_cond: conditions the raw board buttons for the vending FSM and
// turns debounced presses into coin-sensor strobes.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   btn_raw     raw buttons ([4]=coin5 [3]=spare [2]=coin25 [1]=coin100 [0]=coin10)
//   btn_level   debounced level per bit
//   btn_pulse   one-cycle pulse per debounced rise
//   s5/s10/s25/s100  one-cycle accepted-coin strobes
//   coin_value  value of the accepted coin while its strobe is high, else 0
//   coin_err    one-cycle pulse when several coins mature in the same cycle
module coin_sensor_cond
    import coin_pkg::*;
#(
    parameter int unsigned N_BTN     = 5,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BTN-1:0]      btn_raw,
    output logic [N_BTN-1:0]      btn_level,
    output logic [N_BTN-1:0]      btn_pulse,
    output logic                  s5,
    output logic                  s10,
    output logic                  s25,
    output logic                  s100,
    output logic [COIN_VAL_W-1:0] coin_value,
    output logic                  coin_err
);

    logic [2:0] w_nc;
    coin_out_t  w_next;
    coin_out_t  r_coin;

    // One independent conditioner per raw input.
    for (genvar g = 0; g < N_BTN; g++) begin : g_db
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (btn_raw[g]),
            .o_level (btn_level[g]),
            .o_pulse (btn_pulse[g])
        );
    end

    // Coin mapping: exactly one coin pulse is accepted, several are all dropped.
    always_comb begin
        w_nc = 3'(btn_pulse[COIN5_BIT])  + 3'(btn_pulse[COIN10_BIT]) +
               3'(btn_pulse[COIN25_BIT]) + 3'(btn_pulse[COIN100_BIT]);
        w_next = '0;
        if (w_nc == 3'd1) begin
            w_next.s5   = btn_pulse[COIN5_BIT];
            w_next.s10  = btn_pulse[COIN10_BIT];
            w_next.s25  = btn_pulse[COIN25_BIT];
            w_next.s100 = btn_pulse[COIN100_BIT];
            if (btn_pulse[COIN5_BIT]) begin
                w_next.value = COIN5_VAL;
            end else if (btn_pulse[COIN10_BIT]) begin
                w_next.value = COIN10_VAL;
            end else if (btn_pulse[COIN25_BIT]) begin
                w_next.value = COIN25_VAL;
            end else begin
                w_next.value = COIN100_VAL;
            end
        end else if (w_nc >= 3'd2) begin
            w_next.err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_coin <= '0;
        end else begin
            r_coin <= w_next;
        end
    end

    assign s5         = r_coin.s5;
    assign s10        = r_coin.s10;
    assign s25        = r_coin.s25;
    assign s100       = r_coin.s100;
    assign coin_value = r_coin.value;
    assign coin_err   = r_coin.err;

endmodule
